// File: rtl/multichannel_capture_handler_if.sv
// multichannel_capture_handler_if
// Bundles the command bus, the upload-arbiter handshake, the raw channel
// inputs and the overflow flag of the capture handler.
//   master : command source / upload arbiter side (drives cmd_*, channel
//            inputs and upload_ready)
//   slave  : the capture handler itself
interface multichannel_capture_handler_if #(
    parameter int NUM_CH = 16
);
    logic [7:0]        cmd_type;
    logic [15:0]       cmd_length;
    logic [7:0]        cmd_data;
    logic [15:0]       cmd_data_index;
    logic              cmd_start;
    logic              cmd_data_valid;
    logic              cmd_done;
    logic              cmd_ready;
    logic [NUM_CH-1:0] dc_signal_in;
    logic              upload_active;
    logic              upload_req;
    logic [7:0]        upload_data;
    logic [7:0]        upload_source;
    logic              upload_valid;
    logic              upload_ready;
    logic              overflow;

    modport master (
        output cmd_type, cmd_length, cmd_data, cmd_data_index,
               cmd_start, cmd_data_valid, cmd_done, dc_signal_in, upload_ready,
        input  cmd_ready, upload_active, upload_req, upload_data,
               upload_source, upload_valid, overflow
    );

    modport slave (
        input  cmd_type, cmd_length, cmd_data, cmd_data_index,
               cmd_start, cmd_data_valid, cmd_done, dc_signal_in, upload_ready,
        output cmd_ready, upload_active, upload_req, upload_data,
               upload_source, upload_valid, overflow
    );
endinterface

// File: rtl/multichannel_capture_handler.sv
// multichannel_capture_handler
// Samples NUM_CH synchronised channel inputs every max(divider,1) cycles,
// optionally only on change, buffers samples in a FIFO and uploads each one
// as NUM_CH/8 bytes (byte k = channels 8k+7..8k) over a valid/ready handshake.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  slave side of multichannel_capture_handler_if (command bus,
//        channel inputs, upload handshake, sticky overflow flag)
//
// state   | meaning
// IDLE    | waiting for a START command
// RX_CMD  | collecting START payload (divider hi, divider lo, mode)
// CAPTURE | sampling at the divider rate and uploading FIFO contents
// FLUSH   | finishing the in-flight sample after STOP; FIFO discarded
module multichannel_capture_handler #(
    parameter int          NUM_CH      = 16,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd60,
    parameter logic [7:0]  SOURCE_ID   = 8'h0B
) (
    input logic clk,
    input logic rst,
    multichannel_capture_handler_if.slave bus
);
    localparam int          NUM_BYTES = NUM_CH / 8;
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [7:0]  CMD_START = 8'h0B;
    localparam logic [7:0]  CMD_STOP  = 8'h0C;
    localparam logic [3:0]  LAST_BYTE = 4'(NUM_BYTES - 1);
    localparam logic [AW:0] DEPTH_V   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);

    typedef enum logic [1:0] {IDLE, RX_CMD, CAPTURE, FLUSH} state_t;

    state_t            state;
    logic [NUM_CH-1:0] sync1, sync2, prev_sample, shreg, fifo_rdata;
    logic [NUM_CH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr, fifo_cnt;
    logic [15:0]       div, cnt;
    logic              mode, first, busy, ovf;
    logic [3:0]        byte_cnt;
    logic [7:0]        pay_hi, pay_lo, nxt_hi, nxt_lo;
    logic              pay_mode, nxt_mode;
    logic              start_cmd, stop_cmd, tick, want_wr, xfer, last_xfer;
    logic              empty, full, pop, fifo_wr, drop;
    logic              unused_cmd;

    function automatic logic [15:0] period_m1(input logic [15:0] d);
        return (d <= 16'd1) ? 16'd0 : d - 16'd1;
    endfunction

    assign unused_cmd = ^bus.cmd_length;

    assign start_cmd = bus.cmd_start && (bus.cmd_type == CMD_START);
    assign stop_cmd  = bus.cmd_start && (bus.cmd_type == CMD_STOP);

    assign fifo_cnt   = wr_ptr - rd_ptr;
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (fifo_cnt == DEPTH_V);
    assign fifo_rdata = mem[rd_ptr[AW-1:0]];

    // Change-only mode compares against the previous tick's sample even if
    // that sample was not written; the first tick after START always writes.
    assign tick    = (state == CAPTURE) && (cnt == 16'd0);
    assign want_wr = tick && (!mode || first || (sync2 != prev_sample));

    assign xfer      = busy && bus.upload_ready;
    assign last_xfer = xfer && (byte_cnt == 4'd0);
    // Reload while the last byte leaves so samples can go back-to-back.
    assign pop     = (state == CAPTURE) && !stop_cmd && !empty && (!busy || last_xfer);
    // A full FIFO still accepts the write when a pop frees a slot that cycle.
    assign fifo_wr = want_wr && (!full || pop);
    assign drop    = want_wr && full && !pop;

    always_comb begin
        nxt_hi   = pay_hi;
        nxt_lo   = pay_lo;
        nxt_mode = pay_mode;
        if (bus.cmd_data_valid) begin
            case (bus.cmd_data_index)
                16'd0:   nxt_hi   = bus.cmd_data;
                16'd1:   nxt_lo   = bus.cmd_data;
                16'd2:   nxt_mode = bus.cmd_data[0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) mem[wr_ptr[AW-1:0]] <= sync2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sync1       <= '0;
            sync2       <= '0;
            prev_sample <= '0;
            shreg       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            div         <= DEFAULT_DIV;
            cnt         <= '0;
            mode        <= 1'b0;
            first       <= 1'b1;
            busy        <= 1'b0;
            ovf         <= 1'b0;
            byte_cnt    <= '0;
            pay_hi      <= DEFAULT_DIV[15:8];
            pay_lo      <= DEFAULT_DIV[7:0];
            pay_mode    <= 1'b0;
        end else begin
            sync1 <= bus.dc_signal_in;
            sync2 <= sync1;

            if (pop) begin
                shreg    <= fifo_rdata;
                byte_cnt <= LAST_BYTE;
                busy     <= 1'b1;
            end else if (xfer) begin
                shreg <= shreg >> 8;
                if (byte_cnt == 4'd0) busy <= 1'b0;
                else                  byte_cnt <= byte_cnt - 4'd1;
            end

            if (state == CAPTURE) begin
                if (tick) begin
                    cnt         <= period_m1(div);
                    prev_sample <= sync2;
                    first       <= 1'b0;
                end else begin
                    cnt <= cnt - 16'd1;
                end
            end

            if (fifo_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
            if (drop)    ovf    <= 1'b1;

            // Pointer clears below override the increments above.
            case (state)
                IDLE: begin
                    if (start_cmd) begin
                        pay_hi   <= DEFAULT_DIV[15:8];
                        pay_lo   <= DEFAULT_DIV[7:0];
                        pay_mode <= 1'b0;
                        state    <= RX_CMD;
                    end
                end
                RX_CMD: begin
                    if (stop_cmd) begin
                        state <= IDLE;
                    end else begin
                        pay_hi   <= nxt_hi;
                        pay_lo   <= nxt_lo;
                        pay_mode <= nxt_mode;
                        if (bus.cmd_done) begin
                            div    <= {nxt_hi, nxt_lo};
                            mode   <= nxt_mode;
                            cnt    <= period_m1({nxt_hi, nxt_lo});
                            first  <= 1'b1;
                            wr_ptr <= '0;
                            rd_ptr <= '0;
                            ovf    <= 1'b0;
                            state  <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (stop_cmd) begin
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        state  <= (busy && !last_xfer) ? FLUSH : IDLE;
                    end
                end
                FLUSH: begin
                    if (last_xfer) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready     = (state != FLUSH);
    assign bus.upload_active = (state == CAPTURE) || (state == FLUSH);
    assign bus.upload_req    = busy;
    assign bus.upload_valid  = busy;
    assign bus.upload_data   = shreg[7:0];
    assign bus.upload_source = SOURCE_ID;
    assign bus.overflow      = ovf;
endmodule
